// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: op encoding,
// the 4-bit lookahead group function and the WIDTH/SEGS legality check.
package cla_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic       gg;
        logic       gp;
        logic [3:0] c;
    } grp4_t;

    // c[k] is the carry into bit k of the group; gg/gp ignore ci.
    function automatic grp4_t cla_grp4(input logic [3:0] p, input logic [3:0] g, input logic ci);
        grp4_t r;
        r.c[0] = ci;
        r.c[1] = g[0] | (p[0] & ci);
        r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        r.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        r.gp   = &p;
        return r;
    endfunction

    function automatic bit cla_cfg_ok(input int w, input int s);
        return (s >= 1) && (s <= 8) && (w > 0) && ((w % (4 * s)) == 0);
    endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SW-bit two-level carry-lookahead slice: 4-bit groups, then a
// flattened lookahead across the group generate/propagate terms.
module cla_seg
    import cla_pkg::*;
#(
    parameter int SW = 16
) (
    input  logic [SW-1:0] p,
    input  logic [SW-1:0] g,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);

    localparam int NG = SW / 4;

    always_comb begin : p_cla
        grp4_t         v_grp;
        logic [NG-1:0] v_gg;
        logic [NG-1:0] v_gp;
        logic [NG:0]   v_gc;
        logic [SW-1:0] v_c;
        logic          v_t;
        logic          v_or;
        v_grp = '0;
        v_gg  = '0;
        v_gp  = '0;
        v_gc  = '0;
        v_c   = '0;
        v_t   = 1'b0;
        v_or  = 1'b0;
        for (int k = 0; k < NG; k++) begin
            v_grp   = cla_grp4(p[4*k +: 4], g[4*k +: 4], 1'b0);
            v_gg[k] = v_grp.gg;
            v_gp[k] = v_grp.gp;
        end
        // Second level: carry into group k as a sum of products, not a ripple.
        for (int k = 0; k <= NG; k++) begin
            v_or = cin;
            for (int m = 0; m < k; m++) v_or = v_or & v_gp[m];
            for (int j = 0; j < k; j++) begin
                v_t = v_gg[j];
                for (int m = j + 1; m < k; m++) v_t = v_t & v_gp[m];
                v_or = v_or | v_t;
            end
            v_gc[k] = v_or;
        end
        for (int k = 0; k < NG; k++) begin
            v_grp          = cla_grp4(p[4*k +: 4], g[4*k +: 4], v_gc[k]);
            v_c[4*k +: 4]  = v_grp.c;
        end
        sum  = p ^ v_c;
        cout = v_gc[NG];
        cmsb = v_c[SW-1];
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: SEGS register stages, each resolving one
// WIDTH/SEGS slice, with a valid/ready elastic pipeline that collapses bubbles.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SEGS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SW = WIDTH / SEGS;

    if (!cla_cfg_ok(WIDTH, SEGS)) begin : g_cfg_bad
        $error("cla_pipe_adder: WIDTH must be a multiple of 4*SEGS and SEGS in 1..8");
    end

    logic [SEGS-1:0]  r_v;
    logic [SEGS-1:0]  r_c;
    logic [SEGS-1:0]  r_z;
    logic             r_cmsb;
    logic [WIDTH-1:0] r_a   [SEGS];
    logic [WIDTH-1:0] r_b   [SEGS];
    logic [WIDTH-1:0] r_sum [SEGS];

    logic [SEGS:0]    w_rdy;
    logic [WIDTH-1:0] w_sa     [SEGS];
    logic [WIDTH-1:0] w_sb     [SEGS];
    logic [WIDTH-1:0] w_ssum   [SEGS];
    logic [WIDTH-1:0] w_nsum   [SEGS];
    logic [SW-1:0]    w_seg_sum[SEGS];
    logic             w_sc     [SEGS];
    logic             w_sz     [SEGS];
    logic             w_sv     [SEGS];
    logic             w_nz     [SEGS];
    logic             w_seg_co [SEGS];
    logic             w_seg_cm [SEGS];

    always_comb begin
        w_rdy       = '0;
        w_rdy[SEGS] = out_ready;
        for (int i = SEGS - 1; i >= 0; i--) w_rdy[i] = !r_v[i] || w_rdy[i+1];
    end

    assign in_ready = w_rdy[0] && !rst;

    for (genvar i = 0; i < SEGS; i++) begin : g_stage
        if (i == 0) begin : g_src_in
            assign w_sa[i]   = a;
            assign w_sb[i]   = (op == OP_SUB) ? ~b : b;
            assign w_sc[i]   = (op == OP_SUB) ? 1'b1 : cin;
            assign w_ssum[i] = '0;
            assign w_sz[i]   = 1'b1;
            assign w_sv[i]   = in_valid && in_ready;
        end else begin : g_src_reg
            assign w_sa[i]   = r_a[i-1];
            assign w_sb[i]   = r_b[i-1];
            assign w_sc[i]   = r_c[i-1];
            assign w_ssum[i] = r_sum[i-1];
            assign w_sz[i]   = r_z[i-1];
            assign w_sv[i]   = r_v[i-1];
        end

        cla_seg #(.SW(SW)) u_seg (
            .p    (w_sa[i][i*SW +: SW] ^ w_sb[i][i*SW +: SW]),
            .g    (w_sa[i][i*SW +: SW] & w_sb[i][i*SW +: SW]),
            .cin  (w_sc[i]),
            .sum  (w_seg_sum[i]),
            .cout (w_seg_co[i]),
            .cmsb (w_seg_cm[i])
        );

        assign w_nsum[i] = w_ssum[i] | (WIDTH'(w_seg_sum[i]) << (i * SW));
        assign w_nz[i]   = w_sz[i] & ~(|w_seg_sum[i]);
    end

    // Data registers load on every ready cycle, bubbles included; only r_v qualifies them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v    <= '0;
            r_c    <= '0;
            r_z    <= '0;
            r_cmsb <= 1'b0;
            for (int i = 0; i < SEGS; i++) begin
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_sum[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SEGS; i++) begin
                if (w_rdy[i]) begin
                    r_v[i]   <= w_sv[i];
                    r_a[i]   <= w_sa[i];
                    r_b[i]   <= w_sb[i];
                    r_sum[i] <= w_nsum[i];
                    r_c[i]   <= w_seg_co[i];
                    r_z[i]   <= w_nz[i];
                end
            end
            if (w_rdy[SEGS-1]) r_cmsb <= w_seg_cm[SEGS-1];
        end
    end

    assign out_valid = r_v[SEGS-1];
    assign sum       = r_sum[SEGS-1];
    assign cout      = r_c[SEGS-1];
    assign ovf       = r_c[SEGS-1] ^ r_cmsb;
    assign zero      = r_z[SEGS-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed hand-checked vectors on the 64/4 build,
// plus random streams with stalls on 8/2 and 64/1 builds against a wide-add model.
module tb_cla_pipe_adder;

    localparam int SEGS = 4;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        op;
        logic [63:0] s;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
        logic        z;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_a, in_b, sum;
    logic        cin, op, cout, ovf, zero;

    int          n_vec = 0;
    int          n_mis = 0;
    int          n_out = 0;
    int          cyc   = 0;
    bit          lat_on = 1'b0;
    bit          go_rand = 1'b0;
    bit          hold_chk = 1'b0;
    logic [66:0] held;
    vec_t        tv[11];
    exp_t        q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cla_pipe_adder #(.WIDTH(64), .SEGS(SEGS)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(in_a), .b(in_b), .cin(cin), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns {1'b0, cout, ovf, zero, sum} for a w-bit add/sub.
    function automatic logic [67:0] mdl(input int w, input logic [63:0] a_i, input logic [63:0] b_i,
                                        input logic c_i, input logic op_i);
        logic [63:0] msk, aa, bb, s;
        logic [64:0] full;
        logic        co, ov;
        msk  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        aa   = a_i & msk;
        bb   = (op_i ? ~b_i : b_i) & msk;
        full = {1'b0, aa} + {1'b0, bb} + {64'd0, (op_i ? 1'b1 : c_i)};
        s    = full[63:0] & msk;
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {1'b0, co, ov, (s == 64'd0), s};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (hold_chk && !rst) chk("hold", {sum, cout, ovf, zero}, held);
        hold_chk = out_valid && !out_ready && !rst;
        held     = {sum, cout, ovf, zero};
        if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) chk("spurious_out", 1, 0);
            else begin
                e = q.pop_front();
                chk("sum", sum, e.s);
                chk("flags_c_o_z", {cout, ovf, zero}, {e.c, e.o, e.z});
                if (lat_on) chk("latency", cyc - e.cyc, SEGS);
            end
        end
    end

    task automatic stream(input int first, input int cnt, input int maxc, output int acc, output int used);
        acc  = 0;
        used = 0;
        while (acc < cnt && used < maxc) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_a = tv[first+acc].a;
            in_b = tv[first+acc].b;
            cin  = tv[first+acc].cin;
            op   = tv[first+acc].op;
            @(negedge clk);
            used++;
            if (in_ready) begin
                q.push_back('{tv[first+acc].s, tv[first+acc].c, tv[first+acc].o, tv[first+acc].z, cyc});
                acc++;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_empty(input int maxc);
        int n = 0;
        while (q.size() != 0 && n < maxc) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    // Alternate-parameter builds driven with random operands and random stalls.
    for (genvar gi = 0; gi < 2; gi++) begin : g_aux
        localparam int AW = (gi == 0) ? 8 : 64;
        localparam int AS = (gi == 0) ? 2 : 1;
        logic          iv, ir, ov, ordy, ci, opx, co, ox, zx;
        logic [AW-1:0] ax, bx, sx;
        logic [67:0]   aq[$];
        bit            done_r = 1'b0;

        cla_pipe_adder #(.WIDTH(AW), .SEGS(AS)) u_dut (
            .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
            .a(ax), .b(bx), .cin(ci), .op(opx),
            .out_valid(ov), .out_ready(ordy),
            .sum(sx), .cout(co), .ovf(ox), .zero(zx)
        );

        initial begin : drv
            int   sent;
            int   cycles;
            logic took;
            iv = 1'b0; ordy = 1'b1; ax = '0; bx = '0; ci = 1'b0; opx = 1'b0;
            sent = 0; cycles = 0; took = 1'b0;
            wait (go_rand);
            while (sent < 1000 && cycles < 20000) begin
                @(posedge clk); #1;
                if (took) iv = 1'b0;
                if (!iv && $urandom_range(3) != 0) begin
                    iv  = 1'b1;
                    ax  = AW'({$urandom, $urandom});
                    bx  = AW'({$urandom, $urandom});
                    ci  = 1'($urandom_range(1));
                    opx = 1'($urandom_range(1));
                end
                ordy = ($urandom_range(3) != 0);
                @(negedge clk);
                cycles++;
                took = iv && ir;
                if (took) begin
                    aq.push_back(mdl(AW, 64'(ax), 64'(bx), ci, opx));
                    sent++;
                end
            end
            @(posedge clk); #1;
            iv = 1'b0;
            ordy = 1'b1;
            repeat (AS + 4) @(posedge clk);
            chk("rnd_drain", aq.size(), 0);
            chk("rnd_sent", sent, 1000);
            done_r = 1'b1;
        end

        always @(negedge clk) begin
            logic [67:0] e;
            if (ov && ordy) begin
                if (aq.size() == 0) chk("rnd_spurious", 1, 0);
                else begin
                    e = aq.pop_front();
                    chk("rnd_sum", 64'(sx), e[63:0]);
                    chk("rnd_flags", {co, ox, zx}, e[66:64]);
                end
            end
        end
    end

    initial begin
        int acc, used, base, k;
        tv[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
        tv[1]  = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
        tv[3]  = '{64'd1, 64'd2, 1'b0, 1'b0, 64'd3, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1};
        tv[6]  = '{64'hA, 64'hA, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1};
        tv[7]  = '{64'h0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
                   64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0};
        tv[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                   64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_a = 64'h1; in_b = 64'h1; cin = 1'b0; op = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_sum", sum, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        repeat (6) @(negedge clk);
        chk("release_no_output", n_out, 0);

        lat_on = 1'b1;
        for (int v = 0; v < 3; v++) begin
            stream(v, 1, 20, acc, used);
            chk("directed_accept", acc, 1);
            wait_empty(20);
        end

        stream(3, 8, 30, acc, used);
        chk("stream_accept", acc, 8);
        chk("stream_cycles", used, 8);
        wait_empty(20);
        lat_on = 1'b0;

        base = n_out;
        @(posedge clk); #1;
        out_ready = 1'b0;
        stream(3, 8, 10, acc, used);
        chk("bp_accepted", acc, SEGS);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_rise", in_ready, 1);
        wait_empty(20);
        chk("bp_outputs", n_out - base, SEGS);

        base = n_out;
        @(posedge clk); #1;
        out_ready = 1'b0;
        stream(3, 3, 10, acc, used);
        chk("mr_accepted", acc, 3);
        rst = 1'b1;
        q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("mr_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("mr_outputs", n_out - base, 0);
        chk("mr_out_valid", out_valid, 0);

        go_rand = 1'b1;
        k = 0;
        while (!(g_aux[0].done_r && g_aux[1].done_r) && k < 30000) begin
            @(posedge clk);
            k++;
        end
        chk("rnd_done", {g_aux[0].done_r, g_aux[1].done_r}, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
